// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage plus the IF/ID pipeline register of a 5-stage core.
//
// Owns the fetch PC and a one-outstanding-request handshake with instruction
// memory. It accepts branch/jump redirects from EX and stall/flush controls
// from the hazard unit, and presents pc_D / instr_D / valid_D to decode.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  bubble encoding written into IF/ID on flush or empty cycles
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   PC_Write            0 = no new memory request is issued
//   IF_ID_Write         0 = IF/ID register holds its contents
//   flush_D             1 = IF/ID content is killed (becomes a NOP bubble)
//   redirect_valid/_pc  replace the fetch PC with a new target
//   imem_req/_addr      request valid / address (fetch PC)
//   imem_gnt            request accepted this cycle
//   imem_rvalid/_rdata  returned instruction word
//   pc_D, pc_plus4_D    PC of the IF/ID instruction and PC+4
//   instr_D, valid_D    IF/ID instruction word and its valid flag
//
// Optional feature (macro IF_FETCH_PERF_CNT_EN)
//   When defined, adds stall_cnt (edges with IF_ID_Write=0) and flush_cnt
//   (edges with flush_D=1), both 32-bit wrapping counters reset to 0.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        IF_ID_Write,
    input  logic        flush_D,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D,
    output logic [31:0] instr_D,
    output logic        valid_D
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Fetch-side state
    state_t      state_r, state_s;
    logic        started_r;
    logic [31:0] pc_f_r, pc_f_s;
    logic [31:0] fetch_pc_r, fetch_pc_s;
    logic        discard_r, discard_s;

    // One-entry hold buffer for data returned while decode is stalled
    logic        hold_valid_r, hold_valid_s;
    logic [31:0] hold_pc_r, hold_pc_s;
    logic [31:0] hold_instr_r, hold_instr_s;

    // IF/ID register
    logic        valid_d_r, valid_d_s;
    logic [31:0] pc_d_r, pc_d_s;
    logic [31:0] pc_plus4_d_r, pc_plus4_d_s;
    logic [31:0] instr_d_r, instr_d_s;

    // Handshake qualifiers
    logic        req_s;
    logic        accept_s;
    logic        rsp_s;
    logic        rsp_keep_s;

    // Request is suppressed until the first edge after reset so that a
    // request never appears while the block is still coming out of reset.
    assign req_s    = started_r && (state_r == S_REQ) && PC_Write && !redirect_valid;
    assign accept_s = req_s && imem_gnt;
    // Only a response in S_WAIT belongs to our outstanding request.
    assign rsp_s    = (state_r == S_WAIT) && imem_rvalid;
    // A response arriving together with a redirect or flush is wrong-path.
    assign rsp_keep_s = rsp_s && !discard_r && !redirect_valid && !flush_D;

    assign imem_req   = req_s;
    assign imem_addr  = pc_f_r;
    assign pc_D       = pc_d_r;
    assign pc_plus4_D = pc_plus4_d_r;
    assign instr_D    = instr_d_r;
    assign valid_D    = valid_d_r;

    // Next-state logic for the fetch FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_REQ: begin
                if (accept_s) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (rsp_s) begin
                    if (rsp_keep_s && !IF_ID_Write) begin
                        state_s = S_HOLD;
                    end else begin
                        state_s = S_REQ;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_HOLD: begin
                // Buffer drains into IF/ID, or is cleared by flush/redirect.
                if (flush_D || redirect_valid || IF_ID_Write) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_HOLD;
                end
            end
            default: begin
                state_s = S_REQ;
            end
        endcase
    end

    // Fetch PC, in-flight PC and discard flag updates
    always_comb begin
        pc_f_s     = pc_f_r;
        fetch_pc_s = fetch_pc_r;
        discard_s  = discard_r;

        // Redirect takes priority over the post-grant increment.
        if (redirect_valid) begin
            pc_f_s = redirect_pc;
        end else if (accept_s) begin
            pc_f_s = pc_f_r + 32'd4;
        end else begin
            pc_f_s = pc_f_r;
        end

        if (accept_s) begin
            fetch_pc_s = pc_f_r;
        end else begin
            fetch_pc_s = fetch_pc_r;
        end

        // A redirect with a request still in flight marks its response stale.
        // If the response arrives in the same cycle it is dropped directly,
        // so no flag is left behind to kill the next request's data.
        if (redirect_valid && (state_r == S_WAIT) && !imem_rvalid) begin
            discard_s = 1'b1;
        end else if (rsp_s) begin
            discard_s = 1'b0;
        end else begin
            discard_s = discard_r;
        end
    end

    // Hold buffer: captures returned data while IF/ID is stalled
    always_comb begin
        hold_valid_s = hold_valid_r;
        hold_pc_s    = hold_pc_r;
        hold_instr_s = hold_instr_r;
        if (flush_D || redirect_valid) begin
            hold_valid_s = 1'b0;
        end else if (hold_valid_r && IF_ID_Write) begin
            hold_valid_s = 1'b0;
        end else if (rsp_keep_s && !IF_ID_Write) begin
            // Only reachable from S_WAIT, where the buffer is always empty.
            hold_valid_s = 1'b1;
            hold_pc_s    = fetch_pc_r;
            hold_instr_s = imem_rdata;
        end else begin
            hold_valid_s = hold_valid_r;
        end
    end

    // IF/ID register: flush > stall > new data > bubble
    always_comb begin
        valid_d_s    = valid_d_r;
        pc_d_s       = pc_d_r;
        pc_plus4_d_s = pc_plus4_d_r;
        instr_d_s    = instr_d_r;
        if (flush_D) begin
            valid_d_s = 1'b0;
            instr_d_s = NOP_INSTR;
        end else if (!IF_ID_Write) begin
            valid_d_s = valid_d_r;
        end else if (hold_valid_r && !redirect_valid) begin
            valid_d_s    = 1'b1;
            pc_d_s       = hold_pc_r;
            pc_plus4_d_s = hold_pc_r + 32'd4;
            instr_d_s    = hold_instr_r;
        end else if (rsp_keep_s) begin
            valid_d_s    = 1'b1;
            pc_d_s       = fetch_pc_r;
            pc_plus4_d_s = fetch_pc_r + 32'd4;
            instr_d_s    = imem_rdata;
        end else begin
            valid_d_s = 1'b0;
            instr_d_s = NOP_INSTR;
        end
    end

    // State and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_REQ;
            started_r    <= 1'b0;
            pc_f_r       <= RESET_PC;
            fetch_pc_r   <= 32'h0000_0000;
            discard_r    <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_pc_r    <= 32'h0000_0000;
            hold_instr_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0004;
            instr_d_r    <= NOP_INSTR;
        end else begin
            state_r      <= state_s;
            started_r    <= 1'b1;
            pc_f_r       <= pc_f_s;
            fetch_pc_r   <= fetch_pc_s;
            discard_r    <= discard_s;
            hold_valid_r <= hold_valid_s;
            hold_pc_r    <= hold_pc_s;
            hold_instr_r <= hold_instr_s;
            valid_d_r    <= valid_d_s;
            pc_d_r       <= pc_d_s;
            pc_plus4_d_r <= pc_plus4_d_s;
            instr_d_r    <= instr_d_s;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Stall and flush event counters (free-running, wrapping)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
        end else begin
            if (!IF_ID_Write) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_D) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule
